alarm_control_sch: RTL and testbench

- Alarm-setting controller for the digital clock module.
- Two front-panel keys drive it:
  - SW_F1 steps through the alarm-setting modes.
  - SW_F2 acts inside the current mode.
- It issues one-cycle increment strobes to the alarm hour and minute counters, which live outside this block.
- It holds the alarm enable flag.
- It sits between the key inputs and the alarm time registers and comparator.

---
 rtl/alarm_control_sch_pkg.sv | 16 +
 rtl/alarm_control_sch_key_edge_det.sv | 22 ++
 rtl/alarm_control_sch.sv | 70 +++++++
 tb/tb_alarm_control_sch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alarm_control_sch_pkg.sv
// rtl/alarm_control_sch_pkg.sv - shared mode encoding for the alarm-setting controller
package alarm_control_sch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_HOUR  = 2'd1,
    SET_MIN   = 2'd2,
    SET_ONOFF = 2'd3
  } mode_e;

  // Modes form a ring, so the 2-bit increment wraps SET_ONOFF back to IDLE.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/alarm_control_sch_key_edge_det.sv
// rtl/alarm_control_sch_key_edge_det.sv - rising-edge detector for one debounced key
module key_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic key,
  output logic rise
);

  logic prev;

  // History loads the live key during reset too, so a key held through reset is not a press.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev <= key;
    end else begin
      prev <= key;
    end
  end

  assign rise = key & ~prev;

endmodule

// File: rtl/alarm_control_sch.sv
// rtl/alarm_control_sch.sv - alarm mode FSM issuing hour/minute strobes and the enable flag
module alarm_control_sch
  import alarm_control_sch_pkg::*;
#(
  parameter logic ONOFF_INIT = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_F1,
  input  logic SW_F2,
  output logic ALM_HOUR,
  output logic ALM_MIN,
  output logic ALM_ONOFF
);

  logic  f1_rise;
  logic  f2_rise;
  mode_e mode_q;
  mode_e mode_d;
  logic  hour_d;
  logic  min_d;
  logic  onoff_d;

  key_edge_det u_f1_edge (
    .clk    (CLK),
    .resetn (RST),
    .key    (SW_F1),
    .rise   (f1_rise)
  );

  key_edge_det u_f2_edge (
    .clk    (CLK),
    .resetn (RST),
    .key    (SW_F2),
    .rise   (f2_rise)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mode_q    <= IDLE;
      ALM_HOUR  <= 1'b0;
      ALM_MIN   <= 1'b0;
      ALM_ONOFF <= ONOFF_INIT;
    end else begin
      mode_q    <= mode_d;
      ALM_HOUR  <= hour_d;
      ALM_MIN   <= min_d;
      ALM_ONOFF <= onoff_d;
    end
  end

  // A mode-key press wins over a simultaneous action-key press.
  always_comb begin
    mode_d  = mode_q;
    hour_d  = 1'b0;
    min_d   = 1'b0;
    onoff_d = ALM_ONOFF;
    if (f1_rise) begin
      mode_d = next_mode(mode_q);
    end else if (f2_rise) begin
      case (mode_q)
        SET_HOUR:  hour_d  = 1'b1;
        SET_MIN:   min_d   = 1'b1;
        SET_ONOFF: onoff_d = ~ALM_ONOFF;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_control_sch.sv
// tb/tb_alarm_control_sch.sv - self-checking bench for alarm_control_sch
module tb_alarm_control_sch;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SW_F1 = 1'b0;
  logic SW_F2 = 1'b0;
  logic ALM_HOUR;
  logic ALM_MIN;
  logic ALM_ONOFF;

  int checks = 0;
  int errors = 0;

  alarm_control_sch #(.ONOFF_INIT(1'b0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW_F1     (SW_F1),
    .SW_F2     (SW_F2),
    .ALM_HOUR  (ALM_HOUR),
    .ALM_MIN   (ALM_MIN),
    .ALM_ONOFF (ALM_ONOFF)
  );

  initial begin
    #50;
    forever begin
      CLK = 1'b1;
      #50;
      CLK = 1'b0;
      #50;
    end
  end

  // Model: keys counted by consecutive high samples; a press is the first high sample.
  int   f1_cnt = 0;
  int   f2_cnt = 0;
  int   m_mode = 0;
  logic m_hour = 1'b0;
  logic m_min = 1'b0;
  logic m_onoff = 1'b0;
  bit   m_valid = 1'b0;

  always @(posedge CLK) begin
    bit p1;
    bit p2;
    if (!RST) begin
      m_mode  = 0;
      m_hour  = 1'b0;
      m_min   = 1'b0;
      m_onoff = 1'b0;
      f1_cnt  = SW_F1 ? 1 : 0;
      f2_cnt  = SW_F2 ? 1 : 0;
    end else begin
      p1 = SW_F1 && (f1_cnt == 0);
      p2 = SW_F2 && (f2_cnt == 0);
      f1_cnt = SW_F1 ? f1_cnt + 1 : 0;
      f2_cnt = SW_F2 ? f2_cnt + 1 : 0;
      m_hour = 1'b0;
      m_min  = 1'b0;
      if (p1) begin
        m_mode = (m_mode + 1) % 4;
      end else if (p2) begin
        if (m_mode == 1) m_hour = 1'b1;
        if (m_mode == 2) m_min = 1'b1;
        if (m_mode == 3) m_onoff = !m_onoff;
      end
    end
    m_valid = 1'b1;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      check("model_hour", int'(ALM_HOUR), int'(m_hour));
      check("model_min", int'(ALM_MIN), int'(m_min));
      check("model_onoff", int'(ALM_ONOFF), int'(m_onoff));
      check("model_mode", int'(dut.mode_q), m_mode);
      check("hour_min_exclusive", int'(ALM_HOUR & ALM_MIN), 0);
    end
  end

  task automatic go(input longint t);
    #(t - $time);
  endtask

  initial begin
    go(51);
    check("reset_hour", int'(ALM_HOUR), 0);
    check("reset_min", int'(ALM_MIN), 0);
    check("reset_onoff", int'(ALM_ONOFF), 0);
    check("reset_mode", int'(dut.mode_q), 0);
    go(100);  RST = 1'b1;
    go(200);  SW_F2 = 1'b1;
    go(251);  check("idle_f2_hour", int'(ALM_HOUR), 0);
    check("idle_f2_mode", int'(dut.mode_q), 0);
    go(300);  SW_F2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      go(300 + 200 * i); SW_F1 = 1'b1;
      go(351 + 200 * i); check("cycle_mode", int'(dut.mode_q), (i + 1) % 4);
      go(400 + 200 * i); SW_F1 = 1'b0;
    end
    go(1200); SW_F1 = 1'b1;
    go(1300); SW_F1 = 1'b0;
    go(1400); SW_F2 = 1'b1;
    go(1451); check("hour_strobe_on", int'(ALM_HOUR), 1);
    go(1551); check("hour_strobe_off", int'(ALM_HOUR), 0);
    go(1651); check("hour_held_no_repeat", int'(ALM_HOUR), 0);
    go(1700); SW_F2 = 1'b0;
    go(1800); SW_F1 = 1'b1;
    go(1900); SW_F1 = 1'b0;
    go(2000); SW_F2 = 1'b1;
    go(2051); check("min_strobe_on", int'(ALM_MIN), 1);
    check("min_no_hour", int'(ALM_HOUR), 0);
    go(2100); SW_F2 = 1'b0;
    go(2151); check("min_strobe_off", int'(ALM_MIN), 0);
    go(2300); SW_F1 = 1'b1;
    go(2400); SW_F1 = 1'b0;
    go(2451); check("onoff_mode", int'(dut.mode_q), 3);
    go(2500); SW_F2 = 1'b1;
    go(2551); check("onoff_toggle_on", int'(ALM_ONOFF), 1);
    go(2651); check("onoff_held_stays", int'(ALM_ONOFF), 1);
    go(2700); SW_F2 = 1'b0;
    go(2900); SW_F1 = 1'b1;
    go(2951); check("onoff_kept_in_idle", int'(ALM_ONOFF), 1);
    check("back_to_idle", int'(dut.mode_q), 0);
    go(3000); SW_F1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go(3100 + 200 * i); SW_F1 = 1'b1;
      go(3200 + 200 * i); SW_F1 = 1'b0;
    end
    go(3700); SW_F2 = 1'b1;
    go(3751); check("onoff_toggle_off", int'(ALM_ONOFF), 0);
    go(3800); SW_F2 = 1'b0;
    go(3900); SW_F1 = 1'b1;
    go(4000); SW_F1 = 1'b0;
    go(4100); SW_F1 = 1'b1;
    go(4200); SW_F1 = 1'b0;
    go(4300); SW_F1 = 1'b1; SW_F2 = 1'b1;
    go(4351); check("simul_mode_min", int'(dut.mode_q), 2);
    check("simul_no_hour", int'(ALM_HOUR), 0);
    go(4400); SW_F1 = 1'b0; SW_F2 = 1'b0;
    go(4451); check("simul_no_late_min", int'(ALM_MIN), 0);
    go(4600); SW_F1 = 1'b1; SW_F2 = 1'b1; RST = 1'b0;
    go(4800); RST = 1'b1;
    go(4851); check("held_reset_mode", int'(dut.mode_q), 0);
    check("held_reset_hour", int'(ALM_HOUR), 0);
    check("held_reset_min", int'(ALM_MIN), 0);
    go(4951); check("held_reset_mode_late", int'(dut.mode_q), 0);
    go(5000); SW_F1 = 1'b0; SW_F2 = 1'b0;
    go(5200); SW_F1 = 1'b1;
    go(5251); check("post_reset_press", int'(dut.mode_q), 1);
    go(5300); SW_F1 = 1'b0;
    go(5400); SW_F2 = 1'b1;
    go(5451); check("post_reset_hour", int'(ALM_HOUR), 1);
    go(5500); SW_F2 = 1'b0;
    go(5700);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
